// File: rtl/serial_byte_receiver_if.sv
// serial_byte_receiver_if: serial line in, received sample and status out
interface serial_byte_receiver_if #(parameter int DATA_BITS = 8);
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 load;
    logic                 error;
    logic                 busy;
    modport master (input rx, output data_out, load, error, busy);
    modport slave  (output rx, input data_out, load, error, busy);
endinterface

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: oversampled async serial deserialiser (start, LSB-first data, stop)
// Define SERIAL_PARITY_CHECK_EN to add a parity bit between data and stop.
module serial_byte_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic clock,
    input logic reset,
    input logic enable,
    serial_byte_receiver_if.master bus
);
`ifdef SERIAL_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] TOP  = BW'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
    state_t               state;
    logic                 rx_meta, rx_sync, par_bit;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        idx;
    logic [DATA_BITS-1:0] shift, data_q;
    logic                 load_q, error_q, busy_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            par_bit <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            data_q  <= '1;
            load_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            load_q  <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: if (!rx_sync) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                    // Mid-start-bit check rejects glitches shorter than half a bit
                    START: if (cnt == HALF) begin
                        cnt    <= '0;
                        idx    <= '0;
                        state  <= rx_sync ? IDLE : DATA;
                        busy_q <= !rx_sync;
                    end else cnt <= cnt + 1'b1;
                    DATA: if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[DATA_BITS-1:1]};
                        idx   <= idx == TOP ? idx : idx + 1'b1;
                        if (idx == TOP) state <= PAR_EN ? PARITY : STOP;
                    end else cnt <= cnt + 1'b1;
                    PARITY: if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sync;
                        state   <= STOP;
                    end else cnt <= cnt + 1'b1;
                    STOP: if (cnt == LAST) begin
                        cnt     <= '0;
                        state   <= rx_sync ? IDLE : WAIT_IDLE;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        data_q  <= shift;
                        error_q <= !rx_sync || (PAR_EN && (par_bit != ((^shift) ^ PARITY_ODD)));
                    end else cnt <= cnt + 1'b1;
                    // A held-low line must return high before another start is accepted
                    WAIT_IDLE: if (rx_sync) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.data_out = data_q;
    assign bus.load     = load_q;
    assign bus.error    = error_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed frames with hand-computed results for serial_byte_receiver
module tb_serial_byte_receiver;
`ifdef SERIAL_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
    localparam int LAT = 168;
`else
    localparam bit PAR = 1'b0;
    localparam int LAT = 152;
`endif
    logic clock = 1'b0, reset, enable;
    serial_byte_receiver_if #(.DATA_BITS(8)) bus ();
    serial_byte_receiver dut (.clock(clock), .reset(reset), .enable(enable), .bus(bus));
    always #5 clock = ~clock;
    int total = 0, bad = 0, cyc = 0, div = 1, n_load = 0, wide = 0, rises = 0;
    int load_cyc = 0, rise_cyc = 0, n0 = 0, r0 = 0;
    bit gate = 1'b0, load_prev = 1'b0, busy_prev = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clock);
        cyc++;
        if (bus.busy && !busy_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        if (bus.load) begin
            n_load++;
            load_cyc = cyc;
            if (load_prev) wide++;
        end
        load_prev = bus.load;
        busy_prev = bus.busy;
        enable = !gate && (cyc % div == 0);
    endtask
    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (16 * div) step();
    endtask
    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask
    // freeze_at >= 0 stalls enable for a bit time before that data bit while rx toggles
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int freeze_at);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == freeze_at) begin
                gate = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    bus.rx = j[0];
                    step();
                end
                bus.rx = d[i];
                repeat (3) step();
                gate = 1'b0;
            end
            send_bit(d[i]);
        end
        if (PAR) send_bit(par);
        send_bit(stop);
    endtask
    initial begin
        reset = 1'b0;
        enable = 1'b1;
        bus.rx = 1'b1;
        repeat (3) step();
        chk("rst_data", 32'(bus.data_out), 32'hFF);
        chk("rst_load", 32'(bus.load), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        idle(1);
        n0 = n_load;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("mid_busy", 32'(bus.busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_data", 32'(bus.data_out), 32'hFF);
        chk("midrst_load", 32'(bus.load), 0);
        chk("midrst_error", 32'(bus.error), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        bus.rx = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        idle(2);
        chk("midrst_noload", n_load, n0);
        send_frame(8'hA5, ^8'hA5, 1'b1, -1);
        idle(2);
        chk("a5_loads", n_load, n0 + 1);
        chk("a5_data", 32'(bus.data_out), 32'hA5);
        chk("a5_error", 32'(bus.error), 0);
        n0 = n_load;
        send_frame(8'h3C, ^8'h3C, 1'b1, -1);
        idle(2);
        chk("3c_loads", n_load, n0 + 1);
        chk("3c_data", 32'(bus.data_out), 32'h3C);
        chk("3c_error", 32'(bus.error), 0);
        chk("3c_latency", load_cyc - rise_cyc, LAT);
        chk("3c_busy_after", 32'(bus.busy), 0);
        n0 = n_load;
        send_frame(8'h81, ^8'h81, 1'b0, -1);
        repeat (40) send_bit(1'b0);
        chk("81_loads", n_load, n0 + 1);
        chk("81_data", 32'(bus.data_out), 32'h81);
        chk("81_error", 32'(bus.error), 1);
        chk("break_busy", 32'(bus.busy), 0);
        idle(2);
        send_frame(8'h12, ^8'h12, 1'b1, -1);
        idle(2);
        chk("12_loads", n_load, n0 + 2);
        chk("12_data", 32'(bus.data_out), 32'h12);
        chk("12_error", 32'(bus.error), 0);
        n0 = n_load;
        r0 = rises;
        bus.rx = 1'b0;
        repeat (5) step();
        idle(2);
        chk("glitch_busy_rise", rises, r0 + 1);
        chk("glitch_busy_end", 32'(bus.busy), 0);
        chk("glitch_noload", n_load, n0);
        chk("glitch_data", 32'(bus.data_out), 32'h12);
        chk("glitch_error", 32'(bus.error), 0);
        div = 4;
        idle(1);
        send_frame(8'h5A, ^8'h5A, 1'b1, -1);
        idle(2);
        div = 1;
        idle(1);
        chk("5a_loads", n_load, n0 + 1);
        chk("5a_data", 32'(bus.data_out), 32'h5A);
        chk("5a_error", 32'(bus.error), 0);
        send_frame(8'hC3, ^8'hC3, 1'b1, 4);
        idle(2);
        chk("freeze_loads", n_load, n0 + 2);
        chk("freeze_data", 32'(bus.data_out), 32'hC3);
        chk("freeze_error", 32'(bus.error), 0);
`ifdef SERIAL_PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(2);
        chk("par_ok_data", 32'(bus.data_out), 32'h07);
        chk("par_ok_error", 32'(bus.error), 0);
        send_frame(8'h07, 1'b0, 1'b1, -1);
        idle(2);
        chk("par_bad_loads", n_load, n0 + 4);
        chk("par_bad_data", 32'(bus.data_out), 32'h07);
        chk("par_bad_error", 32'(bus.error), 1);
`endif
        chk("load_width", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
